// File: rtl/ravenoc_pkt_rx.sv
// RaveNoC packet receive endpoint: framing check against head LEN, flit FIFO, optional stats.
// Define RAVENOC_PKT_RX_STATS_EN to build the pkt_cnt/err_cnt counters; otherwise they read 0.
module ravenoc_pkt_rx #(
    parameter int FLIT_DATA_W = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   flit_valid,
    input  logic [1:0]             flit_type,
    input  logic [FLIT_DATA_W-1:0] flit_data,
    output logic                   flit_ready,
    output logic                   out_valid,
    output logic [FLIT_DATA_W-1:0] out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_err,
    input  logic                   out_ready,
    output logic [15:0]            pkt_cnt,
    output logic [15:0]            err_cnt
);

    // state     | meaning
    // S_IDLE    | waiting for a HEAD or HEAD_TAIL flit
    // S_PAYLOAD | remaining_q flits of the current packet still expected
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = FLIT_DATA_W + 3;

    localparam logic [1:0] T_HEAD      = 2'b00;
    localparam logic [1:0] T_BODY      = 2'b01;
    localparam logic [1:0] T_TAIL      = 2'b10;
    localparam logic [1:0] T_HEAD_TAIL = 2'b11;

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          wr_en, wr_sop, wr_eop, wr_err, frm_err;
    logic          in_xfer, pop, full, empty, ready_en_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] head_entry;

    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign flit_ready = ready_en_q && !full;
    assign in_xfer    = flit_valid && flit_ready;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        wr_sop      = 1'b0;
        wr_eop      = 1'b0;
        wr_err      = 1'b0;
        frm_err     = 1'b0;
        if (in_xfer) begin
            case (state_q)
                S_IDLE: begin
                    case (flit_type)
                        T_HEAD_TAIL: begin
                            wr_en  = 1'b1;
                            wr_sop = 1'b1;
                            wr_eop = 1'b1;
                        end
                        T_HEAD: begin
                            wr_en  = 1'b1;
                            wr_sop = 1'b1;
                            if (flit_data[7:0] == 8'd0) begin
                                wr_eop  = 1'b1;
                                wr_err  = 1'b1;
                                frm_err = 1'b1;
                            end else begin
                                remaining_d = flit_data[7:0];
                                state_d     = S_PAYLOAD;
                            end
                        end
                        default: frm_err = 1'b1;  // stray BODY/TAIL is dropped
                    endcase
                end
                S_PAYLOAD: begin
                    wr_en = 1'b1;
                    if (remaining_q == 8'd1 && flit_type == T_TAIL) begin
                        wr_eop      = 1'b1;
                        state_d     = S_IDLE;
                        remaining_d = 8'd0;
                    end else if (remaining_q != 8'd1 && flit_type == T_BODY) begin
                        remaining_d = remaining_q - 8'd1;
                    end else begin
                        wr_eop      = 1'b1;
                        wr_err      = 1'b1;
                        frm_err     = 1'b1;
                        state_d     = S_IDLE;
                        remaining_d = 8'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ready_en_q  <= 1'b1;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {wr_err, wr_eop, wr_sop, flit_data};
    end

    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid  = !empty;
    assign out_data   = out_valid ? head_entry[FLIT_DATA_W-1:0] : '0;
    assign out_sop    = out_valid & head_entry[FLIT_DATA_W];
    assign out_eop    = out_valid & head_entry[FLIT_DATA_W+1];
    assign out_err    = out_valid & head_entry[FLIT_DATA_W+2];

`ifdef RAVENOC_PKT_RX_STATS_EN
    logic [15:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pkt_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (wr_en && wr_eop && !wr_err && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (frm_err && err_cnt_q != 16'hFFFF)                    err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign pkt_cnt = 16'd0;
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ravenoc_pkt_rx.sv
// Directed bench for ravenoc_pkt_rx: scoreboard of expected FIFO outputs plus framing/counter checks.
module tb_ravenoc_pkt_rx;
    localparam int W = 32;
`ifdef RAVENOC_PKT_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         flit_valid = 1'b0;
    logic [1:0]   flit_type = 2'b00;
    logic [W-1:0] flit_data = '0;
    logic         flit_ready;
    logic         out_valid, out_sop, out_eop, out_err;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [15:0]  pkt_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int pkt_exp = 0;
    int err_exp = 0;
    logic [W+2:0] sb [$];

    always #5 clk = ~clk;

    ravenoc_pkt_rx #(.FLIT_DATA_W(W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .flit_valid(flit_valid), .flit_type(flit_type), .flit_data(flit_data), .flit_ready(flit_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_err(out_err), .out_ready(out_ready), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input logic sop, input logic eop, input logic err, input logic [W-1:0] d);
        sb.push_back({err, eop, sop, d});
    endtask

    task automatic send(input logic [1:0] t, input logic [W-1:0] d);
        bit done = 1'b0;
        flit_valid = 1'b1;
        flit_type  = t;
        flit_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (flit_ready) done = 1'b1;
            tick();
        end
        flit_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), STATS ? 64'(pkt_exp) : 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), STATS ? 64'(err_exp) : 64'd0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    // Outputs are stable at the falling edge; a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (arst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                chk("out_entry", 64'({out_err, out_eop, out_sop, out_data}), 64'(sb[0]));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_flit_ready", 64'(flit_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flags", 64'({out_err, out_eop, out_sop}), 64'd0);
        chk_cnt("rst");
        arst_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(flit_ready), 64'd1);

        // HEAD LEN=2, BODY, TAIL with one-cycle latency
        out_ready = 1'b1;
        expect_out(1'b1, 1'b0, 1'b0, 32'hA5A5_0002);
        send(T_HEAD, 32'hA5A5_0002);
        chk("t1_head_lat", 64'({out_valid, out_err, out_eop, out_sop}), 64'b1001);
        expect_out(1'b0, 1'b0, 1'b0, 32'h11);
        send(T_BODY, 32'h11);
        chk("t1_body_lat", 64'({out_valid, out_err, out_eop, out_sop}), 64'b1000);
        expect_out(1'b0, 1'b1, 1'b0, 32'h22);
        send(T_TAIL, 32'h22);
        chk("t1_tail_lat", 64'({out_valid, out_err, out_eop, out_sop}), 64'b1010);
        pkt_exp++;
        tick();
        chk_cnt("t1");

        // HEAD_TAIL
        expect_out(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        send(T_HT, 32'hDEAD_BEEF);
        pkt_exp++;
        tick();

        // Stray BODY in IDLE is dropped and counted
        send(T_BODY, 32'h77);
        err_exp++;
        tick();
        chk("t3_no_out", 64'(out_valid), 64'd0);
        chk_cnt("t3");
        expect_out(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        send(T_HT, 32'h1234_5678);
        pkt_exp++;

        // HEAD LEN=3, BODY, HEAD: second head terminates the packet with err
        expect_out(1'b1, 1'b0, 1'b0, 32'h0000_0003);
        send(T_HEAD, 32'h0000_0003);
        expect_out(1'b0, 1'b0, 1'b0, 32'h33);
        send(T_BODY, 32'h33);
        expect_out(1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
        send(T_HEAD, 32'hCAFE_0001);
        err_exp++;
        chk_cnt("t4");
        expect_out(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
        send(T_HT, 32'h0BAD_F00D);
        pkt_exp++;

        // HEAD with LEN=0
        expect_out(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        send(T_HEAD, 32'h0000_0100);
        err_exp++;
        wait_drain("t4");
        chk_cnt("t4b");

        // Fill with out_ready=0, backpressure, pop, wrap
        out_ready = 1'b0;
        expect_out(1'b1, 1'b0, 1'b0, 32'h0000_0105);
        send(T_HEAD, 32'h0000_0105);
        for (int i = 1; i <= 3; i++) begin
            expect_out(1'b0, 1'b0, 1'b0, 32'hB0 + W'(i));
            send(T_BODY, 32'hB0 + W'(i));
        end
        chk("t5_full_ready", 64'(flit_ready), 64'd0);
        chk("t5_head_data", 64'(out_data), 64'h105);
        chk("t5_head_sop", 64'(out_sop), 64'd1);
        tick();
        chk("t5_hold_data", 64'(out_data), 64'h105);
        chk("t5_hold_ready", 64'(flit_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_ready_after_pop", 64'(flit_ready), 64'd1);
        chk("t5_next_data", 64'(out_data), 64'hB1);
        expect_out(1'b0, 1'b0, 1'b0, 32'hB4);
        send(T_BODY, 32'hB4);
        chk("t5_full_again", 64'(flit_ready), 64'd0);
        out_ready = 1'b1;
        expect_out(1'b0, 1'b1, 1'b0, 32'hB5);
        send(T_TAIL, 32'hB5);
        pkt_exp++;
        wait_drain("t5");
        chk_cnt("t5");

        // Reset mid-packet
        out_ready = 1'b0;
        expect_out(1'b1, 1'b0, 1'b0, 32'h0000_0002);
        send(T_HEAD, 32'h0000_0002);
        arst_n = 1'b0;
        #1;
        sb.delete();
        pkt_exp = 0;
        err_exp = 0;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_ready", 64'(flit_ready), 64'd0);
        chk_cnt("t6_rst");
        tick();
        arst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        expect_out(1'b1, 1'b1, 1'b0, 32'hFEED_FACE);
        send(T_HT, 32'hFEED_FACE);
        pkt_exp++;
        wait_drain("t6");
        chk_cnt("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
